// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-triggered interrupt controller with per-source payload capture,
// a pending/mask register pair and an IDLE -> DISPATCH -> SERVICE dispatch FSM.
// Optional build macro IRQ_ROUND_ROBIN_EN switches arbitration from fixed
// lowest-index priority to round-robin starting after the last dispatched id.
//
// Handshake: irq is a one-cycle pulse with irq_id/irq_data valid in that cycle
// (irq_id/irq_data then hold until the next dispatch); there is no ready, the
// consumer acknowledges completion of service with a one-cycle ret pulse.
module irq_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32,
    localparam int ID_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_req,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      mask_we,
    input  logic [NUM_SRC-1:0]        mask_wdata,
    input  logic                      stall,
    input  logic                      ret,
    output logic                      irq,
    output logic [ID_W-1:0]           irq_id,
    output logic [DATA_W-1:0]         irq_data,
    output logic                      in_service,
    output logic [NUM_SRC-1:0]        pending
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        SERVICE  = 2'd2
    } state_t;

    state_t              state;
    logic [NUM_SRC-1:0]  req_q;
    logic [NUM_SRC-1:0]  pend_q;
    logic [NUM_SRC-1:0]  mask_q;
    logic                armed;
    logic [DATA_W-1:0]   data_q [NUM_SRC];

    logic [NUM_SRC-1:0]  edge_v;
    logic [NUM_SRC-1:0]  clr_v;
    logic [NUM_SRC-1:0]  kept_v;
    logic [NUM_SRC-1:0]  set_v;
    logic [NUM_SRC-1:0]  eligible;
    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic                start_dispatch;

    assign pending  = pend_q;
    assign eligible = pend_q & mask_q;
    assign start_dispatch = (state == IDLE) && !stall && win_found;

    // Rising-edge detect; 'armed' blanks the first cycle after reset so a level
    // still high across reset does not count as a new request.
    assign edge_v = src_req & ~req_q & {NUM_SRC{armed}};

    // Pending clear for the source being dispatched, then set-wins merge: an edge
    // lands only on a bit that stays clear after this cycle's clear.
    always_comb begin
        clr_v = '0;
        if (state == DISPATCH) begin
            clr_v[irq_id] = 1'b1;
        end
        kept_v = pend_q & ~clr_v;
        set_v  = edge_v & ~kept_v;
    end

`ifdef IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr;

    // Round-robin search starting one past the last dispatched source.
    always_comb begin : rr_arb
        int          idx;
        logic [ID_W-1:0] idx_c;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr) + 1 + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            idx_c = ID_W'(idx);
            if (!win_found && eligible[idx_c]) begin
                win_found = 1'b1;
                win_id    = idx_c;
            end
        end
    end

    // Remember the last winner; reset value makes the first search start at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= ID_W'(NUM_SRC - 1);
        end else if (start_dispatch) begin
            rr_ptr <= win_id;
        end
    end
`else
    // Fixed priority: lowest eligible index wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[ID_W'(i)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
            end
        end
    end
`endif

    // Request history, pending bits and per-source payload capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= '0;
            armed  <= 1'b0;
            pend_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            req_q  <= src_req;
            armed  <= 1'b1;
            pend_q <= kept_v | set_v;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (set_v[i]) begin
                    data_q[i] <= src_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Mask register; arbitration this cycle still sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '1;
        end else if (mask_we) begin
            mask_q <= mask_wdata;
        end
    end

    // Dispatch FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            irq        <= 1'b0;
            irq_id     <= '0;
            irq_data   <= '0;
            in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_dispatch) begin
                        state      <= DISPATCH;
                        irq        <= 1'b1;
                        irq_id     <= win_id;
                        irq_data   <= data_q[win_id];
                        in_service <= 1'b1;
                    end
                end
                DISPATCH: begin
                    state <= SERVICE;
                    irq   <= 1'b0;
                end
                SERVICE: begin
                    if (ret) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    irq        <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized traffic for irq_ctrl, checked
// against a behavioural model; dispatches are pushed into an expected queue and
// popped by an independent monitor whenever irq is seen.
module tb_irq_ctrl;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    src_req = '0;
    logic [N*W-1:0]  src_data = '0;
    logic            mask_we = 1'b0;
    logic [N-1:0]    mask_wdata = '0;
    logic            stall = 1'b0;
    logic            ret = 1'b0;
    logic            irq;
    logic [IW-1:0]   irq_id;
    logic [W-1:0]    irq_data;
    logic            in_service;
    logic [N-1:0]    pending;

    int total = 0;
    int bad   = 0;

    irq_ctrl #(.NUM_SRC(N), .DATA_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_req    (src_req),
        .src_data   (src_data),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .stall      (stall),
        .ret        (ret),
        .irq        (irq),
        .irq_id     (irq_id),
        .irq_data   (irq_data),
        .in_service (in_service),
        .pending    (pending)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Phase: 0 waiting, 1 announcing (irq cycle), 2 being serviced.
    logic [IW+W-1:0] exp_q [$];
    bit              m_pend [N];
    logic [W-1:0]    m_data [N];
    bit              m_prev [N];
    bit              m_mask [N];
    bit              m_armed;
    int              m_phase;
    int              m_last;
    int              m_disp = 0;
    logic            e_irq = 0;
    logic [IW-1:0]   e_id = '0;
    logic [W-1:0]    e_data = '0;
    logic            e_insvc = 0;

    always @(posedge clk) begin : model
        bit rise [N];
        int w;
        bit found;
        int idx;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_data[i] = '0; m_prev[i] = 0; m_mask[i] = 1;
            end
            m_armed = 0; m_phase = 0; m_last = N - 1;
            e_irq = 0; e_id = '0; e_data = '0; e_insvc = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                rise[i] = m_armed && src_req[i] && !m_prev[i];
            end
            if (m_phase == 0) begin
                if (!stall) begin
                    found = 0; w = 0;
                    for (int k = 0; k < N; k++) begin
`ifdef IRQ_ROUND_ROBIN_EN
                        idx = (m_last + 1 + k) % N;
`else
                        idx = k;
`endif
                        if (!found && m_pend[idx] && m_mask[idx]) begin
                            found = 1; w = idx;
                        end
                    end
                    if (found) begin
                        m_phase = 1; e_irq = 1; e_id = IW'(w); e_data = m_data[w];
                        e_insvc = 1; m_last = w; m_disp++;
                        exp_q.push_back({IW'(w), m_data[w]});
                    end
                end
            end else if (m_phase == 1) begin
                m_pend[e_id] = 0;
                e_irq = 0;
                m_phase = 2;
            end else begin
                if (ret) begin
                    m_phase = 0; e_insvc = 0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (rise[i] && !m_pend[i]) begin
                    m_pend[i] = 1;
                    m_data[i] = src_data[i*W +: W];
                end
            end
            if (mask_we) begin
                for (int i = 0; i < N; i++) m_mask[i] = mask_wdata[i];
            end
            for (int i = 0; i < N; i++) m_prev[i] = src_req[i];
            m_armed = 1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int            n_disp = 0;
    logic [IW-1:0] last_id = '0;
    logic [W-1:0]  last_data = '0;
    logic [IW-1:0] hist [$];

    always @(posedge clk) begin : monitor
        logic [N-1:0]    ep;
        logic [IW+W-1:0] e;
        #2;
        for (int i = 0; i < N; i++) ep[i] = m_pend[i];
        chk("irq", irq, e_irq);
        chk("in_service", in_service, e_insvc);
        chk("pending", pending, ep);
        chk("irq_id_hold", irq_id, e_id);
        chk("irq_data_hold", irq_data, e_data);
        if (irq === 1'b1) begin
            n_disp++;
            last_id = irq_id;
            last_data = irq_data;
            hist.push_back(irq_id);
            if (exp_q.size() == 0) begin
                chk("dispatch_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("dispatch", {irq_id, irq_data}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ret();
        ret = 1'b1;
        step(1);
        ret = 1'b0;
    endtask

    task automatic set_src(input int i, input logic v, input logic [W-1:0] d);
        src_req[i] = v;
        src_data[i*W +: W] = d;
    endtask

    task automatic write_mask(input logic [N-1:0] m);
        mask_we = 1'b1;
        mask_wdata = m;
        step(1);
        mask_we = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int nd;
        rst = 1'b1;
        step(2);
        chk("rst_irq", irq, 0);
        chk("rst_pending", pending, 0);
        chk("rst_in_service", in_service, 0);
        rst = 1'b0;
        step(1);

        // single source with payload
        set_src(2, 1'b1, 32'hDEADBEEF);
        step(4);
        chk("single_id", last_id, 2);
        chk("single_data", last_data, 32'hDEADBEEF);
        chk("single_in_service", in_service, 1);
        pulse_ret();
        set_src(2, 1'b0, '0);
        step(2);
        chk("single_done", in_service, 0);

        // make source 1 the last winner, then two simultaneous sources
        set_src(1, 1'b1, 32'h1111_0001);
        step(4);
        pulse_ret();
        set_src(1, 1'b0, '0);
        step(2);
        set_src(1, 1'b1, 32'h1111_0002);
        set_src(3, 1'b1, 32'h3333_0003);
        step(4);
        pulse_ret();
        step(4);
        pulse_ret();
        set_src(1, 1'b0, '0);
        set_src(3, 1'b0, '0);
        step(2);
`ifdef IRQ_ROUND_ROBIN_EN
        chk("order_first", hist[hist.size()-2], 3);
        chk("order_second", hist[hist.size()-1], 1);
`else
        chk("order_first", hist[hist.size()-2], 1);
        chk("order_second", hist[hist.size()-1], 3);
`endif

        // stall blocks dispatch until it drops
        nd = n_disp;
        stall = 1'b1;
        set_src(0, 1'b1, 32'h0000_5A5A);
        step(5);
        chk("stall_blocks", n_disp, nd);
        stall = 1'b0;
        step(1);
        chk("stall_release", n_disp, nd + 1);
        step(1);
        pulse_ret();
        set_src(0, 1'b0, '0);
        step(2);

        // masked pending waits for unmask
        write_mask(4'b1110);
        nd = n_disp;
        set_src(0, 1'b1, 32'hCAFE_0000);
        step(4);
        chk("mask_pending", pending[0], 1);
        chk("mask_no_irq", n_disp, nd);
        write_mask(4'b1111);
        step(3);
        chk("unmask_id", last_id, 0);
        chk("unmask_data", last_data, 32'hCAFE_0000);
        pulse_ret();
        set_src(0, 1'b0, '0);
        step(2);

        // reset during service with the request held high
        set_src(1, 1'b1, 32'hBEEF_0001);
        step(4);
        rst = 1'b1;
        step(2);
        chk("rst_svc_in_service", in_service, 0);
        chk("rst_svc_irq_id", irq_id, 0);
        chk("rst_svc_irq_data", irq_data, 0);
        chk("rst_svc_pending", pending, 0);
        rst = 1'b0;
        nd = n_disp;
        step(6);
        chk("rst_no_redispatch", n_disp, nd);
        set_src(1, 1'b0, '0);
        step(1);
        set_src(1, 1'b1, 32'hBEEF_0002);
        step(4);
        chk("rst_new_edge", n_disp, nd + 1);
        pulse_ret();
        set_src(1, 1'b0, '0);
        step(2);

        // new edge on the source being cleared in its dispatch cycle
        nd = n_disp;
        set_src(2, 1'b1, 32'hAAAA_0001);
        step(1);
        set_src(2, 1'b0, 32'h0);
        step(1);
        set_src(2, 1'b1, 32'hBBBB_0002);
        step(1);
        chk("collision_pending", pending[2], 1);
        chk("collision_first_data", last_data, 32'hAAAA_0001);
        step(2);
        pulse_ret();
        step(4);
        chk("collision_second", n_disp, nd + 2);
        chk("collision_second_data", last_data, 32'hBBBB_0002);
        pulse_ret();
        set_src(2, 1'b0, '0);
        step(2);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) src_req[i] = ~src_req[i];
            end
            src_data = {$urandom, $urandom, $urandom, $urandom};
            mask_we = ($urandom_range(0, 15) == 0);
            mask_wdata = N'($urandom_range(0, 15));
            stall = ($urandom_range(0, 3) == 0);
            ret = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step(1);
        end

        // drain: unmask everything and keep returning until quiet
        rst = 1'b0;
        stall = 1'b0;
        src_req = '0;
        mask_we = 1'b0;
        write_mask('1);
        for (int c = 0; c < 40; c++) begin
            ret = c[0];
            step(1);
        end
        ret = 1'b0;
        step(2);
        chk("queue_empty", exp_q.size(), 0);
        chk("dispatch_count", n_disp, m_disp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of interrupt sources, legal range 2..16.
REQ-002 SHALL have parameter DATA_W, default 32: width of per-source payload.
REQ-003 SHALL have localparam ID_W = $clog2(NUM_SRC).
REQ-004 SHALL have port clk  in  1: single clock; all logic updates on its rising edge.
REQ-005 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-006 SHALL have port src_req  in  NUM_SRC: per-source request level, synchronous to clk.
REQ-007 SHALL have port src_data  in  NUM_SRC*DATA_W: per-source payload; source i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port mask_we  in  1: mask register write strobe.
REQ-009 SHALL have port mask_wdata  in  NUM_SRC: new mask value; bit = 1 enables the source.
REQ-010 SHALL have port stall  in  1: pipeline busy (a memory access is in flight); dispatch is blocked while high.
REQ-011 SHALL have port ret  in  1: return-from-interrupt pulse (rti/rsi) that ends the current service.
REQ-012 SHALL have port irq  out  1: one-cycle dispatch pulse to fetch.
REQ-013 SHALL have port irq_id  out  ID_W: index of the dispatched source.
REQ-014 SHALL have port irq_data  out  DATA_W: payload of the dispatched source, held until the next dispatch.
REQ-015 SHALL have port in_service  out  1: high from dispatch until ret.
REQ-016 SHALL have port pending  out  NUM_SRC: pending bits, shown irrespective of mask.

Function
REQ-017 SHALL detect a rising edge on each src_req bit against a registered copy of that bit; a level held high SHALL produce exactly one pending set.
REQ-018 SHALL, on a rising edge of source i, set pending[i] and capture src_data slice i into data register i in the same clock edge.
REQ-019 SHALL ignore a repeat edge while pending[i] is already set: no second pending, and data register i keeps its first capture.
REQ-020 SHALL run a state machine with states IDLE, DISPATCH and SERVICE.
REQ-021 SHALL go IDLE->DISPATCH when stall=0 and (pending & mask) != 0; the winner is the lowest index in fixed-priority mode.
REQ-022 SHALL, in DISPATCH (exactly one cycle), drive irq=1 with irq_id/irq_data of the winner, clear that winner's pending bit, then go to SERVICE.
REQ-023 SHALL stay in SERVICE until ret=1, then return to IDLE; the next dispatch is allowed no earlier than the cycle after IDLE is entered.
REQ-024 SHALL ignore ret in IDLE and in DISPATCH.
REQ-025 SHALL give latency as follows: src_req rising at edge k with unmasked, idle and stall=0 SHALL produce irq=1 in the cycle following edge k+1.
REQ-026 SHALL NOT dispatch while stall=1; pending bits are held and dispatch occurs in the first IDLE cycle with stall=0.
REQ-027 SHALL keep a masked pending bit set indefinitely; unmasking it later triggers dispatch.
REQ-028 SHALL arbitrate using the mask value held before a mask write in the same cycle; the new mask takes effect next cycle.
REQ-029 SHALL, when a new edge on a source coincides with that source's pending clear in DISPATCH, make set win: pending stays 1 and new data is captured.
REQ-030 SHALL hold in_service=1 in DISPATCH and SERVICE and 0 in IDLE.

Reset
REQ-031 SHALL, on rst=1, force the state to IDLE and clear pending, the edge registers and the data registers to 0.
REQ-032 SHALL, on rst=1, set mask to all-ones and drive irq=0, irq_id=0, irq_data=0, in_service=0.
REQ-033 SHALL, when rst is asserted during SERVICE, abandon the service with no ret needed, and SHALL NOT register a request edge for a src_req bit that is still high after reset.

Configuration
REQ-034 SHALL, when macro IRQ_ROUND_ROBIN_EN is defined, replace fixed priority with round-robin arbitration: search starts at (last dispatched id + 1) mod NUM_SRC; the pointer resets to NUM_SRC-1, so the first search starts at 0.
REQ-035 SHALL, when IRQ_ROUND_ROBIN_EN is undefined, use fixed lowest-index priority and build no pointer register.

Verification
REQ-036 SHALL cover single source: NUM_SRC=4, src_req[2] 0->1 with data 0xDEADBEEF -> irq pulse 1 cycle, irq_id=2, irq_data=0xDEADBEEF, in_service=1 until ret.
REQ-037 SHALL cover simultaneous sources: src_req[1] and src_req[3] rise in the same cycle, with ret after each dispatch -> dispatch order is 1 then 3 in fixed mode; with IRQ_ROUND_ROBIN_EN and last id=1, order is 3 then 1.
REQ-038 SHALL cover stall: stall=1 for 5 cycles after an edge on src 0 -> no irq; irq appears in the first cycle after stall falls.
REQ-039 SHALL cover mask: mask_wdata=4'b1110, then an edge on src 0 -> pending[0]=1 and no irq; after mask_wdata=4'b1111 -> irq_id=0.
REQ-040 SHALL cover reset mid-service: rst during SERVICE with src_req[1] held high -> all outputs 0 and no dispatch after release until src_req[1] falls and rises again.
REQ-041 SHALL cover the set/clear collision: an edge on src 2 in the DISPATCH cycle of src 2 -> pending[2]=1 afterwards and a second dispatch after ret.
